// File: rtl/i2s_tdm_tx.sv
// I2S/TDM slave-mode serial transmitter with an internal frame FIFO.
// Latency: sck/ws pin edge seen 3 clk later; sd updates on the clk that detects falling sck.
// Backpressure: input_tready = FIFO not full; an empty FIFO at a frame start sends zeros (or repeats).
//
// Ports: clk/rst_n (async active-low); input_tdata/tvalid/tready frame stream (channel 0 in the LSBs);
//        sck/ws async bit clock and frame sync; sd serial data out; fifo_level frames stored;
//        underrun/misalign one-clk status pulses.
// Build option: I2S_TDM_TX_REPEAT_EN retransmits the last frame on underrun instead of zeros.
module i2s_tdm_tx #(
    parameter int WIDTH      = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CHANNELS*WIDTH-1:0]         input_tdata,
    input  logic                              input_tvalid,
    output logic                              input_tready,
    input  logic                              sck,
    input  logic                              ws,
    output logic                              sd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              underrun,
    output logic                              misalign
);

    localparam int FW = CHANNELS * WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(SLOT_WIDTH + 1);
    localparam int SW = $clog2(CHANNELS);

    // The load step happens in the frame-start detection cycle, so only two
    // resting states are needed.
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    // ---------------- pin synchronisers and edge detection ----------------
    // Synchroniser stages reset high so a pin already high at reset release
    // never looks like a rising sck or a ws fall.
    logic [1:0] sck_sync, ws_sync;
    logic       sck_prev, last_ws;
    logic       sck_rise, sck_fall, frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= 2'b11;
            ws_sync  <= 2'b11;
            sck_prev <= 1'b1;
            last_ws  <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[0], sck};
            ws_sync  <= {ws_sync[0], ws};
            sck_prev <= sck_sync[1];
            if (sck_rise)
                last_ws <= ws_sync[1];
        end
    end

    assign sck_rise    = sck_sync[1] & ~sck_prev;
    assign sck_fall    = ~sck_sync[1] & sck_prev;
    // Only the 1->0 ws transition marks a frame, so duty cycle is irrelevant.
    assign frame_start = sck_rise & last_ws & ~ws_sync[1];

    // ---------------- frame FIFO ----------------
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, fifo_empty;

    assign input_tready = (fifo_level != LW'(FIFO_DEPTH));
    assign fifo_empty   = (fifo_level == '0);
    assign push         = input_tvalid & input_tready;
    assign pop          = frame_start & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= input_tdata;
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---------------- serialiser ----------------
    logic [0:0]            state;
    logic [FW-1:0]         frame_reg, frame_new;
    logic [SLOT_WIDTH-1:0] sreg;
    logic [BW-1:0]         bit_cnt;
    logic [SW-1:0]         slot_idx, slot_nxt;
    logic [WIDTH-1:0]      next_chan;

    // Frame taken at a frame start; an empty FIFO yields zeros or the old frame.
    always_comb begin
        frame_new = '0;
        if (!fifo_empty)
            frame_new = mem[rd_ptr];
        else begin
`ifdef I2S_TDM_TX_REPEAT_EN
            frame_new = frame_reg;
`else
            frame_new = '0;
`endif
        end
    end

    assign slot_nxt  = slot_idx + 1'b1;
    assign next_chan = frame_reg[slot_nxt*WIDTH +: WIDTH];

    // Sample sits MSB-aligned in the slot; the tail of the slot shifts out zeros.
    function automatic logic [SLOT_WIDTH-1:0] align(input logic [WIDTH-1:0] s);
        logic [SLOT_WIDTH-1:0] v;
        v = '0;
        v[SLOT_WIDTH-1 -: WIDTH] = s;
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sd        <= 1'b0;
            sreg      <= '0;
            bit_cnt   <= '0;
            slot_idx  <= '0;
            frame_reg <= '0;
            underrun  <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            underrun <= frame_start & fifo_empty;
            misalign <= frame_start & (state == S_SHIFT);
            if (frame_start) begin
                // A frame start always restarts the frame, abandoning any slot in flight.
                frame_reg <= frame_new;
                slot_idx  <= '0;
                sreg      <= align(frame_new[WIDTH-1:0]);
                bit_cnt   <= BW'(SLOT_WIDTH);
                state     <= S_SHIFT;
            end else if (sck_fall) begin
                if (state == S_SHIFT) begin
                    sd      <= sreg[SLOT_WIDTH-1];
                    sreg    <= sreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == BW'(1)) begin
                        if (slot_idx == LAST_SLOT)
                            state <= S_IDLE;
                        else begin
                            slot_idx <= slot_nxt;
                            sreg     <= align(next_chan);
                            bit_cnt  <= BW'(SLOT_WIDTH);
                        end
                    end
                end else begin
                    sd <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
module tb_i2s_tdm_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT a: stereo I2S defaults.  DUT b: 8-channel TDM, 24-bit samples.
    logic [31:0]  a_tdata;
    logic         a_tvalid, a_tready, a_sck, a_ws, a_sd, a_under, a_mis;
    logic [2:0]   a_level;
    logic [191:0] b_tdata;
    logic         b_tvalid, b_tready, b_sck, b_ws, b_sd, b_under, b_mis;
    logic [2:0]   b_level;

    i2s_tdm_tx u_a (
        .clk(clk), .rst_n(rst_n),
        .input_tdata(a_tdata), .input_tvalid(a_tvalid), .input_tready(a_tready),
        .sck(a_sck), .ws(a_ws), .sd(a_sd),
        .fifo_level(a_level), .underrun(a_under), .misalign(a_mis)
    );

    i2s_tdm_tx #(.WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(8), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .input_tdata(b_tdata), .input_tvalid(b_tvalid), .input_tready(b_tready),
        .sck(b_sck), .ws(b_ws), .sd(b_sd),
        .fifo_level(b_level), .underrun(b_under), .misalign(b_mis)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int under_n [2];
    int mis_n   [2];

    always @(negedge clk) begin
        if (a_under) under_n[0] <= under_n[0] + 1;
        if (b_under) under_n[1] <= under_n[1] + 1;
        if (a_mis)   mis_n[0]   <= mis_n[0] + 1;
        if (b_mis)   mis_n[1]   <= mis_n[1] + 1;
    end

    // Reference model: queued frames per DUT and the last frame sent.
    logic [191:0] qa [$];
    logic [191:0] qb [$];
    logic [191:0] last_fr [2];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push(input int dut, input logic [191:0] f);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (dut == 0) begin a_tdata = f[31:0]; a_tvalid = 1'b1; ok = a_tready; end
            else          begin b_tdata = f;       b_tvalid = 1'b1; ok = b_tready; end
            @(posedge clk);
        end
        #1;
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        chk($sformatf("push%0d accepted", dut), ok, 1);
        if (ok) begin
            if (dut == 0) qa.push_back({160'b0, f[31:0]});
            else          qb.push_back(f);
        end
    endtask

    // Frame starts in sck cycles; ws held low for 'lowlen' cycles from each start.
    // One sd sample per sck cycle, taken mid low phase.
    task automatic run(input int dut, input int starts[$], input int lowlen, input int total,
                       output logic got[$], output int du, output int dm);
        int u0, m0;
        u0 = under_n[dut];
        m0 = mis_n[dut];
        got = {};
        for (int c = 0; c < total; c++) begin
            int s;
            logic w;
            s = -1;
            foreach (starts[k]) if (starts[k] <= c) s = starts[k];
            w = (s >= 0 && c - s < lowlen) ? 1'b0 : 1'b1;
            if (dut == 0) begin a_sck = 1'b0; a_ws = w; end
            else          begin b_sck = 1'b0; b_ws = w; end
            repeat (8) @(negedge clk);
            got.push_back(dut == 0 ? a_sd : b_sd);
            if (dut == 0) a_sck = 1'b1; else b_sck = 1'b1;
            repeat (8) @(negedge clk);
        end
        du = under_n[dut] - u0;
        dm = mis_n[dut] - m0;
    endtask

    // Bit j of a frame on the wire: 32-bit slots, sample MSB first, then zeros.
    function automatic logic bitof(input logic [191:0] f, input int dut, input int j);
        int w, slot, b;
        w    = (dut == 0) ? 16 : 24;
        slot = j / 32;
        b    = j % 32;
        if (b >= w) return 1'b0;
        return f[slot*w + w - 1 - b];
    endfunction

    task automatic mk_starts(input int n, input int period, input int jitter, output int st[$]);
        int s;
        s = 0;
        st = {};
        for (int k = 0; k < n; k++) begin
            st.push_back(s);
            s += period + int'($urandom_range(0, jitter));
        end
    endtask

    task automatic check_model(input int dut, input int starts[$], input logic got[$],
                               input int du, input int dm, input string tag);
        int fl, eu, em;
        logic [191:0] fr [$];
        fl = (dut == 0) ? 64 : 256;
        eu = 0;
        em = 0;
        foreach (starts[k]) begin
            logic [191:0] f;
            bit empty;
            empty = (dut == 0) ? (qa.size() == 0) : (qb.size() == 0);
            if (empty) begin
                eu++;
`ifdef I2S_TDM_TX_REPEAT_EN
                f = last_fr[dut];
`else
                f = '0;
`endif
            end else if (dut == 0) f = qa.pop_front();
            else                   f = qb.pop_front();
            last_fr[dut] = f;
            fr.push_back(f);
            if (k > 0 && starts[k] - starts[k-1] < fl) em++;
        end
        for (int k = -1; k < starts.size(); k++) begin
            int lo, hi, nbad;
            lo   = (k < 0) ? 0 : starts[k] + 1;
            hi   = (k + 1 < starts.size()) ? starts[k+1] : got.size() - 1;
            nbad = 0;
            for (int c = lo; c <= hi; c++) begin
                logic e;
                e = 1'b0;
                if (k >= 0 && c - starts[k] - 1 < fl) e = bitof(fr[k], dut, c - starts[k] - 1);
                if (got[c] !== e) nbad++;
            end
            chk($sformatf("%s window %0d bit errors", tag, k), nbad, 0);
        end
        chk($sformatf("%s underrun pulses", tag), du, eu);
        chk($sformatf("%s misalign pulses", tag), dm, em);
    endtask

    typedef struct {
        logic [31:0] tdata;
        logic [63:0] exp;
    } vec_t;

    initial begin
        vec_t tbl [3];
        int st [$];
        logic got [$];
        int du, dm;
        logic [191:0] f, f5;
        logic [63:0] v;
        logic [23:0] sv;
        logic tail;

        tbl[0] = '{32'h1234_A5C3, 64'hA5C3_0000_1234_0000};
        tbl[1] = '{32'h0001_FFFF, 64'hFFFF_0000_0001_0000};
        tbl[2] = '{32'h7FFF_8000, 64'h8000_0000_7FFF_0000};

        rst_n = 1'b0;
        a_tdata = '0; a_tvalid = 1'b0; a_sck = 1'b1; a_ws = 1'b1;
        b_tdata = '0; b_tvalid = 1'b0; b_sck = 1'b1; b_ws = 1'b1;
        last_fr[0] = '0;
        last_fr[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset sd", a_sd, 0);
        chk("reset tready", a_tready, 1);
        chk("reset level", a_level, 0);
        chk("reset underrun", a_under, 0);
        chk("reset misalign", a_mis, 0);
        chk("reset tdm sd", b_sd, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed I2S frames against hand-written bit patterns.
        for (int i = 0; i < 3; i++) begin
            push(0, {160'b0, tbl[i].tdata});
            mk_starts(1, 64, 0, st);
            run(0, st, 32, 66, got, du, dm);
            v = '0;
            for (int j = 0; j < 64; j++) v = {v[62:0], got[j+1]};
            chk($sformatf("table %0d serial", i), v, tbl[i].exp);
            check_model(0, st, got, du, dm, $sformatf("table %0d", i));
        end

        // Backpressure: four frames fill the FIFO, the fifth waits for a pop.
        for (int i = 0; i < 4; i++) push(0, {160'b0, 32'($urandom)});
        @(negedge clk);
        chk("bp tready when full", a_tready, 0);
        chk("bp level when full", a_level, 4);
        f5 = {160'b0, 32'($urandom)};
        a_tdata = f5[31:0];
        a_tvalid = 1'b1;
        repeat (10) @(negedge clk);
        chk("bp level before pop", a_level, 4);
        mk_starts(1, 64, 0, st);
        run(0, st, 32, 65, got, du, dm);
        @(negedge clk);
        a_tvalid = 1'b0;
        qa.push_back(f5);
        chk("bp level after refill", a_level, 4);
        chk("bp tready after refill", a_tready, 0);
        check_model(0, st, got, du, dm, "bp first");
        mk_starts(4, 64, 0, st);
        run(0, st, 32, 258, got, du, dm);
        check_model(0, st, got, du, dm, "bp drain");
        chk("bp level drained", a_level, 0);

        // Underrun: frames with nothing buffered.
        mk_starts(3, 64, 0, st);
        run(0, st, 32, 194, got, du, dm);
        check_model(0, st, got, du, dm, "underrun");

        // Misalign: second frame start 10 sck into slot 1.
        push(0, {160'b0, 32'($urandom)});
        push(0, {160'b0, 32'($urandom)});
        st = {};
        st.push_back(0);
        st.push_back(42);
        run(0, st, 32, 108, got, du, dm);
        check_model(0, st, got, du, dm, "misalign");

        // Asynchronous reset in the middle of a slot.
        push(0, {160'b0, 32'hFFFF_FFFF});
        push(0, {160'b0, 32'($urandom)});
        for (int c = 0; c < 6; c++) begin
            a_sck = 1'b0;
            a_ws  = 1'b0;
            repeat (8) @(negedge clk);
            a_sck = 1'b1;
            repeat (8) @(negedge clk);
        end
        a_sck = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre-reset sd", a_sd, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-reset sd", a_sd, 0);
        chk("mid-reset level", a_level, 0);
        chk("mid-reset tready", a_tready, 1);
        qa.delete();
        qb.delete();
        last_fr[0] = '0;
        last_fr[1] = '0;
        a_sck = 1'b1;
        a_ws  = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push(0, {160'b0, 32'($urandom)});
        mk_starts(1, 64, 0, st);
        run(0, st, 32, 66, got, du, dm);
        check_model(0, st, got, du, dm, "post-reset");

        // Random I2S frames with random idle gaps between frames.
        for (int i = 0; i < 4; i++) push(0, {160'b0, 32'($urandom)});
        mk_starts(4, 64, 6, st);
        run(0, st, 32, st[3] + 67, got, du, dm);
        check_model(0, st, got, du, dm, "random i2s");

        // TDM: one directed frame, then two random ones, 1-sck sync pulses.
        for (int n = 0; n < 8; n++) f[n*24 +: 24] = 24'h100000 + 24'(n);
        push(1, f);
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 6; n++) f[n*32 +: 32] = $urandom;
            push(1, f);
        end
        mk_starts(3, 256, 0, st);
        run(1, st, 1, 773, got, du, dm);
        for (int n = 0; n < 8; n++) begin
            sv = '0;
            for (int j = 0; j < 24; j++) sv = {sv[22:0], got[1 + n*32 + j]};
            chk($sformatf("tdm slot %0d", n), sv, 24'h100000 + 24'(n));
        end
        tail = got[769] | got[770] | got[771] | got[772];
        chk("tdm idle after slot 7", tail, 0);
        check_model(1, st, got, du, dm, "tdm");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_tx.md
# i2s_tdm_tx

Parametrised I2S/TDM serial audio transmitter in slave mode: externally supplied `sck` and `ws` are synchronised into `clk`, and one multi-channel frame per frame-sync is serialised onto `sd`. Frames enter on an AXI-stream style input and are buffered in an internal frame FIFO. Slot width, sample width, channel count and buffer depth are parameters. The block sits between the audio sample pipeline and the codec/DAC pins. It replaces the fixed 2-channel, unbuffered I2S transmitter.

## Interface
- `WIDTH`, 16: sample bits per channel; 8..32.
- `SLOT_WIDTH`, 32: sck cycles per channel slot; must satisfy `SLOT_WIDTH >= WIDTH`.
- `CHANNELS`, 2: slots per frame; 2 gives standard I2S, 4/8/16 give TDM.
- `FIFO_DEPTH`, 4: frames buffered; power of 2, at least 2.
- `clk`  in  1  system clock; must satisfy f_clk >= 8 × f_sck.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `input_tdata`  in  CHANNELS*WIDTH  one frame; channel 0 is in bits [WIDTH-1:0].
- `input_tvalid`  in  1  frame valid.
- `input_tready`  out  1  FIFO not full.
- `sck`  in  1  bit clock, asynchronous to `clk`.
- `ws`  in  1  word select / frame sync, asynchronous to `clk`.
- `sd`  out  1  serial data.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  frames currently stored.
- `underrun`  out  1  one-clk pulse: a frame start found the FIFO empty.
- `misalign`  out  1  one-clk pulse: a frame start arrived before all slots were sent.

## Operation
- `sck` and `ws` each pass through a 2-flop synchroniser. Rising and falling `sck` edges are detected by comparing the synchronised value with its registered previous value.
- On each detected `sck` rising edge, synchronised `ws` is sampled into `last_ws`. A 1→0 transition of `ws` is a frame start. Only this edge is used; ws duty cycle is ignored, so both 50% I2S ws and single-cycle TDM sync pulses work.
- States:
  - IDLE: `sd` = 0.
  - LOAD: on frame start, pop one frame from the FIFO into `frame_reg`, set `slot_idx` = 0, load `sreg` with channel 0, set `bit_cnt` = SLOT_WIDTH, go to SHIFT.
  - SHIFT: on each `sck` falling edge, `sd` takes `sreg` MSB, `sreg` shifts left with 0 fill, and `bit_cnt` decrements. This gives the I2S one-bit delay. Bits WIDTH+1..SLOT_WIDTH of a slot are 0.
  - When `bit_cnt` reaches 0 and `slot_idx` < CHANNELS-1: increment `slot_idx`, load the next channel, set `bit_cnt` = SLOT_WIDTH.
  - When `bit_cnt` reaches 0 and `slot_idx` = CHANNELS-1: go to IDLE.
- Frame start while in SHIFT: pulse `misalign`, abandon the current frame, and perform LOAD immediately.
- Frame start with the FIFO empty: pulse `underrun`; the frame sent is all zeros (see Configuration).
- The first frame start after reset with `sd` idle is a normal LOAD.
- FIFO push and pop in the same clk cycle: `fifo_level` is unchanged. A push when full is impossible because `input_tready` = 0.

## Timing
- Reset values: `sd` = 0, `input_tready` = 1, `fifo_level` = 0, `underrun` = 0, `misalign` = 0. FIFO empty, state IDLE, `last_ws` = 1.
- Pin edge to detection: 3 clk. `sd` updates on the clk edge at which the falling `sck` is detected.
- `input_tready` is registered-free: it equals `fifo_level != FIFO_DEPTH`. An accepted beat is visible in `fifo_level` the next clk.
- FIFO pop occurs in the clk cycle the frame start is detected. `fifo_level` decrements the following clk.
- Asserting `rst_n` mid-frame forces `sd` = 0 immediately and discards all buffered frames.

## Configuration
- `I2S_TDM_TX_REPEAT_EN` defined: on underrun, `frame_reg` keeps its previous contents and the last frame is retransmitted. Before any frame has been accepted, the retransmitted frame is zeros.
- `I2S_TDM_TX_REPEAT_EN` undefined: on underrun, `frame_reg` is cleared and an all-zero frame is transmitted.
- `underrun` pulses in both builds.

## Test plan
- I2S, defaults: push L=0xA5C3, R=0x1234, with ws 50% and 64 sck per frame. Required: sd is 0, then 1010010111000011 followed by 16 zeros in the left slot, then 0001001000110100 followed by 16 zeros in the right slot.
- TDM, CHANNELS=8, WIDTH=24, SLOT_WIDTH=32: push channel n = 0x100000+n, with a 1-sck ws pulse every 256 sck. Required: each slot carries the correct value MSB-first; sd = 0 after slot 7.
- Backpressure: push 5 frames with FIFO_DEPTH=4 and no sck. Required: `input_tready` drops after the 4th frame, `fifo_level` = 4, and the 5th frame is accepted only after the first frame start.
- Underrun: run frames with the FIFO empty.
  - Default build: `underrun` pulses once per frame and sd is all zeros.
  - `I2S_TDM_TX_REPEAT_EN` build: the last frame repeats.
- Misalign: issue a frame start 10 sck into slot 1. Required: `misalign` pulses, and the next bits come from a newly popped frame, slot 0 MSB.
- Async reset mid-slot: required outputs are sd=0, fifo_level=0 and input_tready=1 immediately; after reset is released, the next frame start gives normal output.
